jtmx5k_pal_arb: RTL and testbench

JTMX5K_PAL_ARB -- requirements
Module: jtmx5k_pal_arb

---
 rtl/jtmx5k_pkg.sv | 34 +++
 rtl/jtmx5k_pal_wbuf.sv | 34 +++
 rtl/jtmx5k_pal_arb.sv | 154 +++++++++++++++
 tb/tb_jtmx5k_pal_arb.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtmx5k_pkg.sv
// Shared definitions for the jtmx5k palette arbiter: slot and read-FSM encodings,
// default palette address width and the slot ownership rule.
package jtmx5k_pkg;

    localparam int PAL_AW = 10;

    typedef enum logic [1:0] {
        SLOT0 = 2'd0,
        SLOT1 = 2'd1,
        SLOT2 = 2'd2,
        SLOT3 = 2'd3
    } slot_t;

    typedef enum logic [2:0] {
        RD_IDLE  = 3'd0,
        RD_DRAIN = 3'd1,
        RD_ISSUE = 3'd2,
        RD_CAPT  = 3'd3,
        RD_HOLD  = 3'd4
    } rd_state_t;

    // Slots 2-3 always belong to the CPU; slots 0-1 only when that pixel is blanked.
    function automatic logic cpu_owns(slot_t s, logic act_now, logic act_pixel);
        logic owns;
        owns = 1'b0;
        case (s)
            SLOT0:   owns = ~act_now;
            SLOT1:   owns = ~act_pixel;
            default: owns = 1'b1;
        endcase
        return owns;
    endfunction

endpackage

// File: rtl/jtmx5k_pal_wbuf.sv
// One-entry posted-write buffer: holds a CPU write until the arbiter
// finds a free RAM slot for it.
module jtmx5k_pal_wbuf
    import jtmx5k_pkg::*;
#(
    parameter int AW = PAL_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fill,
    input  logic [AW-1:0] fill_addr,
    input  logic [7:0]    fill_data,
    input  logic          drain,
    output logic          full,
    output logic [AW-1:0] addr,
    output logic [7:0]    data
);

    // Fill is only offered while empty and drain only while full, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (drain) begin
            full <= 1'b0;
        end else if (fill) begin
            full <= 1'b1;
            addr <= fill_addr;
            data <= fill_data;
        end
    end

endmodule

// File: rtl/jtmx5k_pal_arb.sv
// Palette RAM arbiter: shares a single-port palette RAM between the video
// fetch (two bytes per pixel) and CPU accesses with posted writes.
module jtmx5k_pal_arb
    import jtmx5k_pkg::*;
#(
    parameter int AW = PAL_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    input  logic          LHBL,
    input  logic          LVBL,
    input  logic [AW-2:0] vid_addr,
    output logic [14:0]   vid_rgb,
    input  logic          cpu_cs,
    input  logic          cpu_rnw,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_dout,
    output logic [7:0]    cpu_din,
    output logic          cpu_wait,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    input  logic [7:0]    ram_q
);

    slot_t         slot_q;
    slot_t         slot;
    logic          vid_act;
    logic          act_q;
    logic [7:0]    lo_q;
    logic [6:0]    hi_q;
    rd_state_t     st;
    rd_state_t     st_nx;
    logic          wr_done;
    logic          buf_full;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_data;
    logic          rd_req;
    logic          wr_req;
    logic          wr_acc;
    logic          cpu_slot;
    logic          drain;
    logic          rd_issue;

    assign vid_act  = LHBL & LVBL;
    assign slot     = pxl_cen ? SLOT0 : slot_q;
    assign cpu_slot = cpu_owns(slot, vid_act, act_q);
    assign rd_req   = cpu_cs & cpu_rnw;
    assign wr_req   = cpu_cs & ~cpu_rnw & ~wr_done;
    assign wr_acc   = wr_req & ~buf_full;
    assign drain    = buf_full & cpu_slot;

    // act_q remembers whether the pixel being fetched was visible, so the
    // colour loaded at the next pxl_cen is either the fetched word or black.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q  <= SLOT3;
            act_q   <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            vid_rgb <= '0;
        end else begin
            if (pxl_cen) begin
                slot_q  <= SLOT1;
                act_q   <= vid_act;
                vid_rgb <= act_q ? {hi_q, lo_q} : 15'd0;
            end else if (slot_q != SLOT3) begin
                slot_q <= slot_t'(slot_q + 2'd1);
            end
            if (act_q && slot == SLOT1) lo_q <= ram_q;
            if (act_q && slot == SLOT2) hi_q <= ram_q[6:0];
        end
    end

    // A held chip select must not post the same write twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       wr_done <= 1'b0;
        else if (!cpu_cs) wr_done <= 1'b0;
        else if (wr_acc)  wr_done <= 1'b1;
    end

    jtmx5k_pal_wbuf #(.AW(AW)) u_wbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .fill      (wr_acc),
        .fill_addr (cpu_addr),
        .fill_data (cpu_dout),
        .drain     (drain),
        .full      (buf_full),
        .addr      (buf_addr),
        .data      (buf_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= RD_IDLE;
            cpu_din <= '0;
        end else begin
            st <= st_nx;
            if (st == RD_CAPT) cpu_din <= ram_q;
        end
    end

    // A pending posted write always reaches RAM before a read is issued,
    // so reads observe the CPU's own earlier writes.
    always_comb begin
        st_nx    = st;
        rd_issue = 1'b0;
        case (st)
            RD_IDLE: begin
                if (rd_req) st_nx = buf_full ? RD_DRAIN : RD_ISSUE;
            end
            RD_DRAIN: begin
                if (!rd_req)       st_nx = RD_IDLE;
                else if (!buf_full) st_nx = RD_ISSUE;
            end
            RD_ISSUE: begin
                if (!rd_req) begin
                    st_nx = RD_IDLE;
                end else if (cpu_slot && !buf_full) begin
                    rd_issue = 1'b1;
                    st_nx    = RD_CAPT;
                end
            end
            RD_CAPT: st_nx = rd_req ? RD_HOLD : RD_IDLE;
            RD_HOLD: begin
                if (!cpu_cs) st_nx = RD_IDLE;
            end
            default: st_nx = RD_IDLE;
        endcase
    end

    // RAM port and stall outputs are forced quiet while reset is held.
    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        ram_we   = 1'b0;
        cpu_wait = 1'b0;
        if (rst_n) begin
            cpu_wait = (rd_req && st != RD_HOLD) || (wr_req && buf_full);
            if (!cpu_slot) begin
                ram_addr = {vid_addr, slot == SLOT1};
            end else if (drain) begin
                ram_addr = buf_addr;
                ram_din  = buf_data;
                ram_we   = 1'b1;
            end else if (rd_issue) begin
                ram_addr = cpu_addr;
            end
        end
    end

endmodule

// File: tb/tb_jtmx5k_pal_arb.sv
// Self-checking bench for jtmx5k_pal_arb: a behavioural palette RAM plus a
// memory-semantics scoreboard for CPU traffic and a per-pixel colour model.
module tb_jtmx5k_pal_arb;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pxl_cen = 1'b0;
    logic          LHBL = 1'b1;
    logic          LVBL = 1'b1;
    logic [AW-2:0] vid_addr = '0;
    logic [14:0]   vid_rgb;
    logic          cpu_cs = 1'b0;
    logic          cpu_rnw = 1'b1;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_dout = '0;
    logic [7:0]    cpu_din;
    logic          cpu_wait;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_we;
    logic [7:0]    ram_q;

    logic [7:0] ram   [0:(1<<AW)-1];
    logic [7:0] model [0:(1<<AW)-1];

    int tests  = 0;
    int failed = 0;
    int phase  = 0;

    jtmx5k_pal_arb #(.AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pxl_cen  (pxl_cen),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .vid_addr (vid_addr),
        .vid_rgb  (vid_rgb),
        .cpu_cs   (cpu_cs),
        .cpu_rnw  (cpu_rnw),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .cpu_din  (cpu_din),
        .cpu_wait (cpu_wait),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_q    (ram_q)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one clock of read latency.
    always @(posedge clk) begin
        ram_q <= ram[ram_addr];
        if (ram_we) ram[ram_addr] = ram_din;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Phase tracks the slot the DUT should be in; pxl_cen pulses every 4 clocks.
    task automatic tick();
        @(posedge clk);
        #1;
        phase   = (phase + 1) % 4;
        pxl_cen = (phase == 0);
        #1;
    endtask

    task automatic goto_phase(input int p);
        tick();
        while (phase != p) tick();
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] d);
        int n;
        n = 0;
        cpu_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = a; cpu_dout = d;
        #1;
        while (cpu_wait && n < 40) begin tick(); n++; end
        if (cpu_wait) begin
            tests++; failed++;
            $display("[TB] FAIL write_timeout addr=%h wait still %b, required 0", a, cpu_wait);
        end
        tick();
        cpu_cs = 1'b0;
        #1;
        tick();
        model[a] = d;
    endtask

    task automatic cpu_read(input logic [AW-1:0] a, output logic [7:0] d, output bit ok);
        int n;
        n = 0;
        cpu_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = a;
        #1;
        while (cpu_wait && n < 40) begin tick(); n++; end
        ok = !cpu_wait;
        d  = cpu_din;
        cpu_cs = 1'b0;
        #1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cpu_cs = 1'b1; cpu_rnw = 1'b1; vid_addr = 9'h1AB;
        repeat (3) tick();
        tests++;
        if ({vid_rgb, cpu_din, cpu_wait, ram_we, ram_addr, ram_din} !== '0) begin
            failed++;
            $display("[TB] FAIL reset_outputs rgb=%h din=%h wait=%b we=%b addr=%h wdata=%h, required all 0",
                     vid_rgb, cpu_din, cpu_wait, ram_we, ram_addr, ram_din);
        end
        cpu_cs = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_video_read();
        goto_phase(3);
        vid_addr = 9'h152; LHBL = 1'b1; LVBL = 1'b1;
        tick();
        tests++;
        if (ram_addr !== 10'h2A4 || ram_we !== 1'b0) begin
            failed++;
            $display("[TB] FAIL video_slot0 addr=%h we=%b, required 2a4/0", ram_addr, ram_we);
        end
        tick();
        tests++;
        if (ram_addr !== 10'h2A5 || ram_we !== 1'b0) begin
            failed++;
            $display("[TB] FAIL video_slot1 addr=%h we=%b, required 2a5/0", ram_addr, ram_we);
        end
        goto_phase(0);
        tick();
        tests++;
        if (vid_rgb !== 15'h7C1F) begin
            failed++;
            $display("[TB] FAIL video_rgb got %h, required 7c1f", vid_rgb);
        end
    endtask

    task automatic test_video_random();
        logic [14:0] exp_prev;
        logic [8:0]  a;
        logic        hb, vb;
        bit          have_prev;
        have_prev = 0;
        exp_prev  = '0;
        for (int i = 0; i < 24; i++) begin
            goto_phase(3);
            a  = 9'($urandom);
            hb = ($urandom_range(0, 3) != 0);
            vb = ($urandom_range(0, 3) != 0);
            vid_addr = a; LHBL = hb; LVBL = vb;
            tick();
            tick();
            if (have_prev) begin
                tests++;
                if (vid_rgb !== exp_prev) begin
                    failed++;
                    $display("[TB] FAIL video_random[%0d] got %h, required %h", i, vid_rgb, exp_prev);
                end
            end
            exp_prev  = (hb && vb) ? {ram[{a, 1'b1}][6:0], ram[{a, 1'b0}]} : 15'd0;
            have_prev = 1;
        end
        LHBL = 1'b1; LVBL = 1'b1;
    endtask

    task automatic test_posted_write();
        goto_phase(0);
        cpu_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = 10'h010; cpu_dout = 8'h55;
        #1;
        tests++;
        if (cpu_wait !== 1'b0) begin
            failed++;
            $display("[TB] FAIL posted_wait got %b, required 0", cpu_wait);
        end
        tick();
        cpu_cs = 1'b0;
        #1;
        tests++;
        if (ram_we !== 1'b0) begin
            failed++;
            $display("[TB] FAIL posted_slot1_we got %b, required 0", ram_we);
        end
        tick();
        tests++;
        if (ram_we !== 1'b1 || ram_addr !== 10'h010 || ram_din !== 8'h55) begin
            failed++;
            $display("[TB] FAIL posted_drain we=%b addr=%h data=%h, required 1/010/55", ram_we, ram_addr, ram_din);
        end
        tick();
        model[10'h010] = 8'h55;
    endtask

    task automatic test_back_to_back();
        goto_phase(0);
        cpu_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = 10'h011; cpu_dout = 8'hAA;
        tick();
        cpu_cs = 1'b0;
        tick();
        cpu_cs = 1'b1; cpu_addr = 10'h012; cpu_dout = 8'hBB;
        #1;
        tests++;
        if (cpu_wait !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 10'h011 || ram_din !== 8'hAA) begin
            failed++;
            $display("[TB] FAIL b2b_drain1 wait=%b we=%b addr=%h data=%h, required 1/1/011/aa",
                     cpu_wait, ram_we, ram_addr, ram_din);
        end
        tick();
        tests++;
        if (cpu_wait !== 1'b0) begin
            failed++;
            $display("[TB] FAIL b2b_accept wait=%b, required 0", cpu_wait);
        end
        tick();
        cpu_cs = 1'b0;
        goto_phase(2);
        tests++;
        if (ram_we !== 1'b1 || ram_addr !== 10'h012 || ram_din !== 8'hBB) begin
            failed++;
            $display("[TB] FAIL b2b_drain2 we=%b addr=%h data=%h, required 1/012/bb", ram_we, ram_addr, ram_din);
        end
        tick();
        tests++;
        if (ram[10'h011] !== 8'hAA || ram[10'h012] !== 8'hBB) begin
            failed++;
            $display("[TB] FAIL b2b_ram got %h %h, required aa bb", ram[10'h011], ram[10'h012]);
        end
        model[10'h011] = 8'hAA;
        model[10'h012] = 8'hBB;
    endtask

    task automatic test_read_after_write();
        logic [7:0] d;
        bit         ok;
        cpu_write(10'h300, 8'h3C);
        cpu_read(10'h300, d, ok);
        tests++;
        if (!ok || d !== 8'h3C) begin
            failed++;
            $display("[TB] FAIL read_after_write ok=%b data=%h, required 1/3c", ok, d);
        end
    endtask

    task automatic test_blanking();
        logic [7:0] exp;
        exp = ram[10'h155];
        goto_phase(3);
        LHBL = 1'b0;
        cpu_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = 10'h155;
        tick();
        tests++;
        if (ram_addr !== 10'h155 || ram_we !== 1'b0) begin
            failed++;
            $display("[TB] FAIL blank_slot0 addr=%h we=%b, required 155/0", ram_addr, ram_we);
        end
        tick();
        tests++;
        if (cpu_wait !== 1'b1) begin
            failed++;
            $display("[TB] FAIL blank_capt_wait got %b, required 1", cpu_wait);
        end
        tick();
        tests++;
        if (cpu_wait !== 1'b0 || cpu_din !== exp) begin
            failed++;
            $display("[TB] FAIL blank_read wait=%b data=%h, required 0/%h", cpu_wait, cpu_din, exp);
        end
        cpu_cs = 1'b0;
        goto_phase(0);
        tick();
        tests++;
        if (vid_rgb !== 15'd0) begin
            failed++;
            $display("[TB] FAIL blank_rgb got %h, required 0", vid_rgb);
        end
        LHBL = 1'b1;
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d;
        bit         ok;
        goto_phase(3);
        vid_addr = 9'h152; LHBL = 1'b1; LVBL = 1'b1;
        tick();
        goto_phase(3);
        cpu_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = 10'h300;
        tick();
        tick();
        tests++;
        if (vid_rgb !== 15'h7C1F || cpu_wait !== 1'b1) begin
            failed++;
            $display("[TB] FAIL pre_reset rgb=%h wait=%b, required 7c1f/1", vid_rgb, cpu_wait);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({vid_rgb, cpu_din, cpu_wait, ram_we, ram_addr, ram_din} !== '0) begin
            failed++;
            $display("[TB] FAIL midread_reset rgb=%h din=%h wait=%b we=%b addr=%h wdata=%h, required all 0",
                     vid_rgb, cpu_din, cpu_wait, ram_we, ram_addr, ram_din);
        end
        cpu_cs = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        cpu_read(10'h300, d, ok);
        tests++;
        if (!ok || d !== 8'h3C) begin
            failed++;
            $display("[TB] FAIL post_reset_read ok=%b data=%h, required 1/3c", ok, d);
        end
    endtask

    task automatic test_cpu_random();
        logic [AW-1:0] a;
        logic [7:0]    d;
        bit            ok;
        for (int i = 0; i < 16; i++) model[10'h380 + i] = ram[10'h380 + i];
        vid_addr = 9'h020;
        for (int i = 0; i < 40; i++) begin
            goto_phase(3);
            LHBL = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) tick();
            a = 10'h380 + 10'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                cpu_write(a, 8'($urandom));
            end else begin
                cpu_read(a, d, ok);
                tests++;
                if (!ok || d !== model[a]) begin
                    failed++;
                    $display("[TB] FAIL random_read[%0d] addr=%h ok=%b got %h, required %h", i, a, ok, d, model[a]);
                end
            end
        end
        repeat (8) tick();
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (ram[10'h380 + i] !== model[10'h380 + i]) begin
                failed++;
                $display("[TB] FAIL random_ram addr=%h got %h, required %h",
                         10'h380 + i, ram[10'h380 + i], model[10'h380 + i]);
            end
        end
        LHBL = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]   = 8'($urandom);
            model[i] = ram[i];
        end
        ram[10'h2A4] = 8'h1F;
        ram[10'h2A5] = 8'h7C;
        ram[10'h300] = 8'h00;
        test_reset();
        test_video_read();
        test_video_random();
        test_posted_write();
        test_back_to_back();
        test_read_after_write();
        test_blanking();
        test_reset_mid_read();
        test_cpu_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
